// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown sequencer: state encodings and widths.
package countdown_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HOLD   = 2'b10,
    ST_EXPIRE = 2'b11
  } state_t;

endpackage

// File: rtl/down_counter_core.sv
// Down-counter datapath: synchronous load, decrement-enable that saturates at
// zero, and a terminal-approach flag (count == 1).
module down_counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign is_one = (count == WIDTH'(1));

endmodule

// File: rtl/countdown_seq_ctrl.sv
// Countdown sequencer: FSM plus prescaler around down_counter_core.
// Priority each cycle is ABORT > PAUSE > decrement tick > START.
module countdown_seq_ctrl
  import countdown_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [WIDTH-1:0]   LOAD_VAL,
  input  logic               START,
  input  logic               PAUSE,
  input  logic               ABORT,
  input  logic               RELOAD_EN,
  output logic [WIDTH-1:0]   QOUT,
  output logic               BUSY,
  output logic               DONE,
  output logic [STATE_W-1:0] STATE
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  state_t          state;
  logic [PS_W-1:0] prescaler;
  logic            tick;
  logic            ld_start;
  logic            ld_reload;
  logic            core_load;
  logic [WIDTH-1:0] core_val;
  logic            core_dec;
  logic            is_one;
  logic            load_nonzero;

  assign load_nonzero = (LOAD_VAL != '0);
  assign tick         = (state == ST_RUN) && (prescaler == PS_LAST);

  always_comb begin
    ld_start  = (state == ST_IDLE) && START && !ABORT;
    ld_reload = (state == ST_EXPIRE) && !ABORT && RELOAD_EN && load_nonzero;
    // ABORT loads zero in every state; in IDLE/EXPIRE the count is already zero.
    core_load = ld_start || ld_reload || ABORT;
    core_val  = (ld_start || ld_reload) ? LOAD_VAL : '0;
    core_dec  = tick && !ABORT && !PAUSE;
  end

  down_counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .CLK     (CLK),
    .RESET   (RESET),
    .load    (core_load),
    .load_val(core_val),
    .dec     (core_dec),
    .count   (QOUT),
    .is_one  (is_one)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      prescaler <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          prescaler <= '0;
          if (ld_start) state <= load_nonzero ? ST_RUN : ST_EXPIRE;
        end
        ST_RUN: begin
          if (ABORT) begin
            state     <= ST_IDLE;
            prescaler <= '0;
          end else if (PAUSE) begin
            state <= ST_HOLD;
          end else if (tick) begin
            prescaler <= '0;
            if (is_one) state <= ST_EXPIRE;
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        ST_HOLD: begin
          // Prescaler stays frozen so the partial period resumes where it left off.
          if (ABORT) begin
            state     <= ST_IDLE;
            prescaler <= '0;
          end else if (!PAUSE) begin
            state <= ST_RUN;
          end
        end
        ST_EXPIRE: begin
          prescaler <= '0;
          state     <= ld_reload ? ST_RUN : ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          prescaler <= '0;
        end
      endcase
    end
  end

  assign BUSY  = (state != ST_IDLE);
  assign DONE  = (state == ST_EXPIRE);
  assign STATE = state;

endmodule
